// File: rtl/apb3_requester_arbiter_pkg.sv
// Shared types and limits for the APB3 requester arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb3_arbiter_pkg;

    // Bus sequencer states: wait for a request, APB SETUP phase, APB ACCESS phase.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    localparam int MaxRequesters = 8;

endpackage

// File: rtl/apb3_requester_arbiter_if.sv
// APB3 bus bundle between the arbiter (master) and one completer (slave).
// Latency: n/a (wires only).
// Backpressure: completer stalls the transfer by holding pready low.
// Signals: paddr/pselx/penable/pwrite/pwdata from master; pready/prdata/pslverr from slave.
interface apb3_requester_arbiter_if #(
    parameter int AddressWidth = 20,
    parameter int DataWidth    = 32
);
    logic [AddressWidth-1:0] paddr;
    logic                    pselx;
    logic                    penable;
    logic                    pwrite;
    logic [DataWidth-1:0]    pwdata;
    logic                    pready;
    logic [DataWidth-1:0]    prdata;
    logic                    pslverr;

    modport master (
        output paddr, pselx, penable, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pselx, penable, pwrite, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb3_requester_arbiter_round_robin_arbiter.sv
// Round-robin picker: grants the first set request strictly after ptr_i, wrapping.
// Latency: purely combinational; the pointer register lives in the parent.
// Backpressure: none; caller decides when a grant is consumed.
// Ports: req_i requests, ptr_i last winner, grant_o one-hot winner, any_o any request set.
module round_robin_arbiter #(
    parameter int N    = 2,
    parameter int PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic            any_o
);

    int   idx;
    logic found;

    // Scan N positions starting one past the last winner; the last position
    // visited is the previous winner itself, so it only wins when alone.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/apb3_requester_arbiter.sv
// Shares one APB3 bus among NumRequesters request ports with round-robin arbitration.
// Latency: grant cycle to rsp_valid pulse is 3 cycles minimum, plus completer wait states.
// Backpressure: req_ready pulses only on grant; pready stalls ACCESS, bounded by TimeoutCycles.
// Ports: clk/rst_n; req_* request side (packed per requester); rsp_* response side;
//        apb master modport carries the APB3 bus.
module apb3_requester_arbiter
    import apb3_arbiter_pkg::*;
#(
    parameter int NumRequesters = 2,
    parameter int AddressWidth  = 20,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NumRequesters-1:0]          req_valid,
    input  logic [NumRequesters-1:0]          req_write,
    input  logic [NumRequesters*AddressWidth-1:0] req_addr,
    input  logic [NumRequesters*DataWidth-1:0]    req_wdata,
    output logic [NumRequesters-1:0]          req_ready,
    output logic [NumRequesters-1:0]          rsp_valid,
    output logic [DataWidth-1:0]              rsp_rdata,
    output logic                              rsp_error,
    apb3_requester_arbiter_if.master          apb
);

    if (NumRequesters < 1 || NumRequesters > MaxRequesters) begin : g_bad_param
        $fatal(1, "apb3_requester_arbiter: NumRequesters must be 1..8");
    end

    localparam int PtrW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
    localparam int TmoW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [TmoW-1:0] TmoLast = (TimeoutCycles > 0) ? TmoW'(TimeoutCycles - 1) : '0;

    state_e                   state_q, state_d;
    logic [PtrW-1:0]          ptr_q, ptr_d;
    logic [NumRequesters-1:0] owner_q, owner_d;
    logic [AddressWidth-1:0]  paddr_q, paddr_d;
    logic                     pwrite_q, pwrite_d;
    logic [DataWidth-1:0]     pwdata_q, pwdata_d;
    logic                     psel_q, psel_d;
    logic                     penable_q, penable_d;
    logic [TmoW-1:0]          tmo_q, tmo_d;
    logic [NumRequesters-1:0] rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                     rsp_error_q, rsp_error_d;

    logic [NumRequesters-1:0] arb_grant;
    logic                     arb_any;
    int unsigned              gnt_idx;
    logic                     tmo_hit;

    round_robin_arbiter #(
        .N    (NumRequesters),
        .PtrW (PtrW)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .any_o   (arb_any)
    );

    always_comb begin
        gnt_idx = 0;
        for (int i = 0; i < NumRequesters; i++) begin
            if (arb_grant[i]) gnt_idx = i;
        end
    end

    // This ACCESS cycle without pready is the one that brings the count to the limit.
    assign tmo_hit = (TimeoutCycles != 0) && (tmo_q == TmoLast);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        tmo_d       = tmo_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready = arb_grant;
                    owner_d   = arb_grant;
                    ptr_d     = PtrW'(gnt_idx);
                    paddr_d   = req_addr[gnt_idx*AddressWidth +: AddressWidth];
                    pwrite_d  = req_write[gnt_idx];
                    pwdata_d  = req_write[gnt_idx] ? req_wdata[gnt_idx*DataWidth +: DataWidth] : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // pready has priority over a timeout landing in the same cycle.
                if (apb.pready) begin
                    rsp_valid_d = owner_q;
                    rsp_error_d = apb.pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : apb.prdata;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = IDLE;
                end else if (tmo_hit) begin
                    rsp_valid_d = owner_q;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = IDLE;
                end else if (TimeoutCycles != 0) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= PtrW'(NumRequesters - 1);
            owner_q     <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            tmo_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign apb.paddr   = paddr_q;
    assign apb.pselx   = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;

endmodule
